cpu_sequencer: RTL
==================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: program counter value loaded on reset.
REQ-002 Parameter PC_STEP, default 4: sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction fetch request, held until imem_ack.
REQ-006 imem_addr  output  32  fetch address, equal to current PC.
REQ-007 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  latched instruction, fed to decoder.
REQ-010 dec_valid  output  1  one-cycle pulse: instr is valid for decode.
REQ-011 halt_op  input  1  decoder flag, sampled in DECODE: instruction is a halt.
REQ-012 mem_op  input  1  decoder flag, sampled in DECODE: instruction needs a data-memory phase.
REQ-013 alu_start  output  1  one-cycle pulse starting ALU execution.
REQ-014 alu_done  input  1  ALU result, pc_load and pc_target valid this cycle.
REQ-015 pc_load  input  1  ALU branch/jump taken, sampled with alu_done.
REQ-016 pc_target  input  32  branch/jump destination, sampled with alu_done.
REQ-017 dmem_req  output  1  data-memory request, held until dmem_ack.
REQ-018 dmem_ack  input  1  data-memory access complete.
REQ-019 rd_we  output  1  one-cycle register-file write enable.
REQ-020 pc  output  32  architectural program counter.
REQ-021 retired  output  32  retired-instruction counter.
REQ-022 halted  output  1  sequencer stopped (halt or fault).
REQ-023 fault  output  1  misaligned branch target detected.

Function
REQ-024 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; one-hot or binary at implementer's choice.
REQ-025 FETCH: imem_req=1, imem_addr=pc, both stable until imem_ack; on imem_ack, instr<=imem_rdata, next state DECODE.
REQ-026 DECODE: dec_valid=1 for exactly one cycle; halt_op=1 -> HALT; otherwise mem_op is latched and next state is EXEC.
REQ-027 EXEC: alu_start=1 only in the first EXEC cycle; wait any number of cycles for alu_done.
REQ-028 On alu_done: latch pc_load and pc_target; next state MEM if latched mem_op=1, else WB.
REQ-029 alu_done while in EXEC with pc_load=1 and pc_target[1:0]!=0 SHALL set fault=1, go to HALT, and suppress rd_we and the PC update.
REQ-030 MEM: dmem_req=1 until dmem_ack; on dmem_ack, next state WB.
REQ-031 WB: rd_we=1 for exactly one cycle; pc<=pc_target if latched pc_load else pc+PC_STEP modulo 2^32; retired<=retired+1 modulo 2^32; next state FETCH.
REQ-032 Minimum instruction latency (zero-wait acks, no MEM) SHALL be 4 cycles FETCH-to-FETCH.
REQ-033 HALT: halted=1, all request/pulse outputs 0, pc and retired frozen; exit only via reset.
REQ-034 imem_ack, alu_done and dmem_ack SHALL be ignored in any state other than the one awaiting them.
REQ-035 At most one of imem_req, dmem_req, alu_start, rd_we, dec_valid SHALL be high in any cycle.

Reset
REQ-036 reset=1 SHALL immediately (without a clock edge) force state FETCH, pc=RESET_PC, retired=0, instr=0, halted=0, fault=0, and all request/pulse outputs to 0.
REQ-037 Reset asserted mid-transaction SHALL drop imem_req/dmem_req the same cycle; imem_req reasserts with imem_addr=RESET_PC on the first rising edge after reset is released.

Verification
REQ-038 Straight line: 3 non-mem instructions, zero-wait acks, pc_load=0 -> pc 0,4,8,12; retired=3; each instruction takes 4 cycles.
REQ-039 Wait states: imem_ack delayed 3 cycles, alu_done delayed 2 -> imem_addr stable throughout; exactly one alu_start pulse; rd_we once.
REQ-040 Branch plus memory: mem_op=1, dmem_ack after 2 cycles, pc_load=1, pc_target=32'h40 -> MEM phase observed; next imem_addr=32'h40.
REQ-041 Fault: pc_load=1, pc_target=32'h42 -> fault=1, halted=1, rd_we never asserted, pc unchanged.
REQ-042 Halt and wrap: pc=32'hFFFF_FFFC sequential -> pc wraps to 0; then halt_op=1 -> halted=1; later acks ignored.
REQ-043 Async reset during MEM with dmem_req=1 -> dmem_req drops without a clock edge; pc=RESET_PC, retired=0.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// ============================================================================
// Module  : cpu_sequencer_if
// Brief   : Fetch / decode / ALU / data-memory handshake bundle of the sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface cpu_sequencer_if;
  // instruction fetch
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // decode
  logic [31:0] instr;
  logic        dec_valid;
  logic        halt_op;
  logic        mem_op;
  // execute
  logic        alu_start;
  logic        alu_done;
  logic        pc_load;
  logic [31:0] pc_target;
  // data memory and write-back
  logic        dmem_req;
  logic        dmem_ack;
  logic        rd_we;
  // architectural status
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halted;
  logic        fault;

  modport master (
    output imem_req, imem_addr, instr, dec_valid, alu_start, dmem_req, rd_we,
           pc, retired, halted, fault,
    input  imem_ack, imem_rdata, halt_op, mem_op, alu_done, pc_load, pc_target,
           dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, instr, dec_valid, alu_start, dmem_req, rd_we,
           pc, retired, halted, fault,
    output imem_ack, imem_rdata, halt_op, mem_op, alu_done, pc_load, pc_target,
           dmem_ack
  );
endinterface

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module  : cpu_sequencer
// Brief   : Multi-cycle FETCH/DECODE/EXEC/MEM/WB instruction sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.master bus
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [31:0] C_PC_STEP = 32'(PC_STEP);

  logic [2:0]  state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] retired_q,   retired_d;
  logic [31:0] instr_q,     instr_d;
  logic [31:0] target_q,    target_d;
  logic        load_q,      load_d;
  logic        mem_op_q,    mem_op_d;
  logic        fault_q,     fault_d;
  logic        alu_first_q, alu_first_d;
  // Low while reset is held and until the first edge after release, so the
  // fetch request only appears once the core is actually running.
  logic        run_q;

  logic        misaligned;

  assign misaligned = bus.pc_load && (bus.pc_target[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    instr_d     = instr_q;
    target_d    = target_q;
    load_d      = load_q;
    mem_op_d    = mem_op_q;
    fault_d     = fault_q;
    alu_first_d = alu_first_q;

    case (state_q)
      ST_FETCH: begin
        if (run_q && bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (bus.halt_op) begin
          state_d = ST_HALT;
        end else begin
          mem_op_d    = bus.mem_op;
          alu_first_d = 1'b1;
          state_d     = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_first_d = 1'b0;
        if (bus.alu_done) begin
          load_d   = bus.pc_load;
          target_d = bus.pc_target;
          // A misaligned taken branch stops here: no write-back, PC untouched.
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else if (mem_op_q) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_MEM: begin
        if (bus.dmem_ack) begin
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        pc_d      = load_q ? target_q : (pc_q + C_PC_STEP);
        retired_d = retired_q + 32'd1;
        state_d   = ST_FETCH;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      retired_q   <= 32'd0;
      instr_q     <= 32'd0;
      target_q    <= 32'd0;
      load_q      <= 1'b0;
      mem_op_q    <= 1'b0;
      fault_q     <= 1'b0;
      alu_first_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      retired_q   <= retired_d;
      instr_q     <= instr_d;
      target_q    <= target_d;
      load_q      <= load_d;
      mem_op_q    <= mem_op_d;
      fault_q     <= fault_d;
      alu_first_q <= alu_first_d;
      run_q       <= 1'b1;
    end
  end

  // Outputs decode straight from state so reset clears them without an edge.
  assign bus.imem_req  = (state_q == ST_FETCH) && run_q;
  assign bus.imem_addr = pc_q;
  assign bus.instr     = instr_q;
  assign bus.dec_valid = (state_q == ST_DECODE);
  assign bus.alu_start = (state_q == ST_EXEC) && alu_first_q;
  assign bus.dmem_req  = (state_q == ST_MEM);
  assign bus.rd_we     = (state_q == ST_WB);
  assign bus.pc        = pc_q;
  assign bus.retired   = retired_q;
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.fault     = fault_q;

endmodule

`default_nettype wire
